// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// Module  : seg7_pkg
// Brief   : Shared types and constants for the 8-digit seven-segment scanner.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g (bit6..bit0), entry 15 first so index n selects hex n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ----------------------------------------------------------------------------
// Module  : hex_to_seg7
// Brief   : Combinational hex nibble to active-low seven-segment decoder.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// Module  : seg7_scan_driver
// Brief   : Time-multiplexed 8-digit hex display driver with frame-aligned
//           value updates and optional leading-zero blanking.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = seg7_pkg::NUM_DIGITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] data_in_i,
  input  logic        blank_lz_i,
  output logic [6:0]  out7_o,
  output logic [7:0]  en_out_o,
  output logic        pending_o,
  output logic        commit_o
);

  import seg7_pkg::*;

  localparam int               DIV_W      = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_t           state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [2:0]       digit_q,   digit_d;
  logic [31:0]      shadow_q,  shadow_d;
  logic [31:0]      display_q, display_d;
  logic             pending_q, pending_d;
  logic             commit_q,  commit_d;
  logic [6:0]       out7_q,    out7_d;
  logic [7:0]       en_q,      en_d;

  logic             w_tick;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic [31:0]      w_upper;
  logic             w_blank;

  assign w_tick   = (state_q == ST_SCAN) && (div_q == DIV_LAST);
  assign w_nibble = display_q[{digit_q, 2'b00} +: 4];
  // Nibbles at and above the current digit, shifted down; zero means a leading zero.
  assign w_upper  = display_q >> {digit_q, 2'b00};
  assign w_blank  = blank_lz_i && (digit_q != 3'd0) && (w_upper == 32'd0);

  hex_to_seg7 u_dec (
    .nibble_i (w_nibble),
    .seg_o    (w_seg)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    digit_d   = digit_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    commit_d  = 1'b0;
    out7_d    = SEG_BLANK;
    en_d      = 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d   = ST_SCAN;
          shadow_d  = data_in_i;
          display_d = data_in_i;
          pending_d = 1'b0;
          commit_d  = 1'b1;
          div_d     = '0;
          digit_d   = 3'd0;
        end
      end
      ST_SCAN: begin
        if (w_tick) begin
          div_d   = '0;
          digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
          if ((digit_q == LAST_DIGIT) && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
            commit_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        // A load on the boundary cycle re-arms pending after the old shadow moves out.
        if (load_i) begin
          shadow_d  = data_in_i;
          pending_d = 1'b1;
        end
        en_d   = ~(8'b1 << digit_q);
        out7_d = w_blank ? SEG_BLANK : w_seg;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      digit_q   <= 3'd0;
      shadow_q  <= 32'd0;
      display_q <= 32'd0;
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      out7_q    <= SEG_BLANK;
      en_q      <= 8'hFF;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      out7_q    <= out7_d;
      en_q      <= en_d;
    end
  end

  assign out7_o    = out7_q;
  assign en_out_o  = en_q;
  assign pending_o = pending_q;
  assign commit_o  = commit_q;

endmodule

`default_nettype wire
